// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter clocked by clk, paced by baud_clk.
// baud_clk (one period per bit) is synchronised into clk and edge-detected
// into a one-cycle baud_tick. Bytes are accepted with in_valid/in_ready while
// idle and shifted out LSB first: start, DATA_BITS data, [parity], stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even when PARITY_ODD=0, odd when PARITY_ODD=1). Default build has none.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int            IW        = $clog2(DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  // Elaboration-time guards on the legal parameter ranges.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // [0],[1] synchronise baud_clk; [2] holds the previous synchronised level.
  // All reset high so a baud_clk already high at release is not an edge.
  logic [2:0]           sync_q;
  logic                 baud_tick;
  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        idx;
  logic                 stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  // Synchronise baud_clk into clk and keep one extra stage for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], baud_clk};
  end

  assign baud_tick = sync_q[1] & ~sync_q[2];

  // Frame FSM; every output is registered and changes on the tick that
  // enters the state whose bit it carries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      shreg    <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          // Accept takes priority over a coincident tick: that tick is dropped.
          if (in_valid && in_ready) begin
            shreg    <= in_data;
`ifdef UART_TX_PARITY_EN
            par_q    <= (^in_data) ^ 1'(PARITY_ODD);
`endif
            state    <= S_WAIT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          // Hold the line high until the next bit boundary.
          if (baud_tick) begin
            state <= S_START;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_tick) begin
            state <= S_DATA;
            idx   <= '0;
            tx    <= shreg[0];
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (idx != IDX_LAST) begin
              idx   <= idx + IW'(1);
              tx    <= shreg[1];
              shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            end else begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= par_q;
`else
              state    <= S_STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            state    <= S_STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          tx <= 1'b1;
          if (baud_tick) begin
            if (stop_cnt == STOP_LAST) begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: baud_clk is a 10-cycle square wave derived from a cycle
// counter, so the tick cycles are known arithmetically. Each frame is modelled
// as a list of line levels; the expected level at any cycle is the entry
// selected by how many ticks have passed since the accepting edge.
module tb_uart_tx;

  localparam int DB = 8;
  localparam int SB = 1;
  localparam int PO = 0;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          baud_clk = 1'b1;
  logic          in_valid = 1'b0;
  logic [DB-1:0] in_data  = '0;
  logic          in_ready;
  logic          tx;
  logic          busy;

  int cyc    = 0;
  int base   = 0;
  bit run    = 1'b0;
  int checks = 0;
  int errors = 0;

  uart_tx #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PO)) dut (
    .clk      (clk),
    .reset    (reset),
    .baud_clk (baud_clk),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // cyc = number of rising clk edges so far.
  always @(posedge clk) cyc = cyc + 1;

  // Baud clock: high for 5, low for 5; rises when (cyc-base) is a multiple of 10.
  always @(negedge clk) baud_clk = run ? (((cyc - base) % 10) < 5) : 1'b1;

  // A rise seen first at edge base+10k+1 is consumed as a tick at edge base+10k+3.
  function automatic bit is_tick(input int c);
    return run && ((c - base) >= 13) && (((c - base) % 10) == 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, tx, 1);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Send one byte and follow the whole frame cycle by cycle.
  // align: make the accepting edge coincide with a tick.
  // ign_k: after tick ign_k, pulse in_valid with 0x3C (must be ignored).
  // rst_k: 3 cycles after tick rst_k, assert reset and abandon the frame.
  task automatic run_frame(input logic [DB-1:0] d, input bit align,
                           input int ign_k, input int rst_k);
    bit exp_bits[$];
    int k        = 0;
    int len;
    int waited   = 0;
    int last_tk  = 0;
    bit ign_on   = 1'b0;
    bit ign_done = 1'b0;
    logic e_tx;

    exp_bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back((^d) ^ PO[0]);
`endif
    for (int i = 0; i < SB; i++) exp_bits.push_back(1'b1);
    len = exp_bits.size();

    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    if (align) begin
      waited = 0;
      while (!is_tick(cyc + 1) && waited < 20) begin
        @(posedge clk); #1;
        waited++;
      end
    end

    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = DB'($urandom);
    chk("acc_tx", tx, 1);
    chk("acc_busy", busy, 1);
    chk("acc_rdy", in_ready, 0);

    for (int n = 0; n < 400 && k <= len; n++) begin
      @(posedge clk); #1;
      if (ign_on) begin
        in_valid = 1'b0;
        in_data  = DB'($urandom);
        ign_on   = 1'b0;
      end
      if (is_tick(cyc)) begin
        k++;
        last_tk = cyc;
      end
      e_tx = (k >= 1 && k <= len) ? exp_bits[k-1] : 1'b1;
      chk("tx", tx, e_tx);
      chk("busy", busy, (k <= len) ? 1 : 0);
      chk("rdy", in_ready, (k > len) ? 1 : 0);
      if (k == ign_k && !ign_done) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
        ign_on   = 1'b1;
        ign_done = 1'b1;
      end
      if (k == rst_k && cyc == last_tk + 3) begin
        reset = 1'b0;
        #1;
        chk_idle("rst_now");
        repeat (4) @(posedge clk);
        #1;
        chk_idle("rst_hold");
        reset = 1'b1;
        return;
      end
    end
    if (k <= len) chk("frame_timeout", k, len + 1);
  endtask

  initial begin
    // Reset with baud_clk high, then a long quiet idle.
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      chk_idle("idle");
    end

    // Second reset with baud_clk high; the baud clock starts at release and a
    // byte is offered at once, so any spurious release tick would shift it.
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    run   = 1'b1;
    base  = cyc;
    run_frame(8'hA5, 1'b0, -1, -1);

    // Back-to-back: second byte offered the cycle in_ready rises.
    run_frame(8'h00, 1'b0, -1, -1);
    run_frame(8'hFF, 1'b0, -1, -1);

    // in_valid pulse mid-frame is ignored.
    run_frame(8'h96, 1'b0, 3, -1);

    // Reset during data bit 3, then a clean frame.
    run_frame(8'hF0, 1'b0, -1, 5);
    repeat (20) @(posedge clk);
    #1;
    chk_idle("post_rst");
    run_frame(8'h55, 1'b0, -1, -1);

`ifdef UART_TX_PARITY_EN
    run_frame(8'h07, 1'b0, -1, -1);
    run_frame(8'h03, 1'b0, -1, -1);
`endif

    // Accept on the same edge as a tick.
    run_frame(8'h3A, 1'b1, -1, -1);

    // Randomised bytes, gaps and tick alignment.
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 25)) @(posedge clk);
      #1;
      run_frame(DB'($urandom), ($urandom % 4) == 0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
